// File: rtl/vram_arbiter_pkg.sv
// Shared types and widths for the VGA/CPU video-memory arbiter.
package vram_arbiter_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 48;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    GAP
  } state_t;

  typedef enum logic {
    OWN_VGA,
    OWN_CPU
  } owner_t;
endpackage

// File: rtl/vram_arb_watchdog.sv
// ISSUE-phase watchdog: counts cycles while active and flags the cycle the limit is reached.
module vram_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_reg;

  // Count restarts from zero every time ISSUE is entered, since active drops in between.
  assign expired = active && (count_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (!active || expired) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Shares one 48-bit video memory port between VGA refill (priority) and CPU with bounded starvation.
// Optional ISSUE watchdog and arb_err abort pulse enabled by defining VRAM_ARB_TIMEOUT_EN.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int VGA_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_sel,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              cpu_sel,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_err
);
  localparam int BURST_W = ($clog2(VGA_BURST + 1) > 3) ? $clog2(VGA_BURST + 1) : 3;

  state_t              state_reg;
  owner_t              owner_reg;
  logic [BURST_W-1:0]  burst_cnt_reg;
  logic                mem_req_reg;
  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [DATA_W-1:0]   vga_data_reg;
  logic [DATA_W-1:0]   cpu_rdata_reg;
  logic                vga_valid_reg;
  logic                cpu_valid_reg;
  logic                vga_grant;
  logic                cpu_grant;
  logic                wd_expired;
  logic [DATA_W-1:0]   resp_data;

  // VGA wins unless the CPU has been passed over VGA_BURST times in a row.
  assign vga_grant = vga_sel && (!cpu_sel || (burst_cnt_reg < BURST_W'(VGA_BURST)));
  assign cpu_grant = cpu_sel && !vga_grant;

  // An aborted access returns zero data to the owner.
  assign resp_data = mem_ack ? mem_rdata : '0;

`ifdef VRAM_ARB_TIMEOUT_EN
  logic arb_err_reg;

  vram_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (state_reg == ISSUE),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arb_err_reg <= 1'b0;
    end else begin
      arb_err_reg <= (state_reg == ISSUE) && !mem_ack && wd_expired;
    end
  end

  assign arb_err = arb_err_reg;
`else
  assign wd_expired = 1'b0;
  assign arb_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_VGA;
      burst_cnt_reg <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      vga_data_reg  <= '0;
      cpu_rdata_reg <= '0;
      vga_valid_reg <= 1'b0;
      cpu_valid_reg <= 1'b0;
    end else begin
      vga_valid_reg <= 1'b0;
      cpu_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (vga_grant || cpu_grant) begin
            owner_reg     <= vga_grant ? OWN_VGA : OWN_CPU;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= cpu_grant && cpu_we;
            mem_addr_reg  <= vga_grant ? vga_addr : cpu_addr;
            mem_wdata_reg <= vga_grant ? '0 : cpu_wdata;
            if (cpu_grant) begin
              burst_cnt_reg <= '0;
            end else if (cpu_sel && (burst_cnt_reg < BURST_W'(VGA_BURST))) begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack || wd_expired) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
            if (owner_reg == OWN_VGA) begin
              vga_data_reg  <= resp_data;
              vga_valid_reg <= 1'b1;
            end else begin
              if (!mem_we_reg) begin
                cpu_rdata_reg <= resp_data;
              end
              cpu_valid_reg <= 1'b1;
            end
            state_reg <= RESP;
          end
        end
        RESP:    state_reg <= GAP;
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign vga_data  = vga_data_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign vga_valid = vga_valid_reg;
  assign cpu_valid = cpu_valid_reg;
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-clock arbiter sharing one 48-bit video/frame memory port between the VGA refill requester (read-only, latency-critical) and the CPU bus requester (read/write). It sits between the `vga` block's `vga_sel`/`vga_addr`/`vga_data`/`vga_valid` handshake, the CPU bus bridge, and the memory controller. It enforces VGA priority with a bounded-starvation guarantee for the CPU, and returns read data with a one-cycle valid pulse.

## Interface
- `VGA_BURST`, 4: maximum consecutive VGA grants while the CPU is pending.
- `TIMEOUT`, 255: `mem_ack` watchdog limit in cycles. Used only with `VRAM_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: asynchronous, active-low reset.
- `vga_sel` in 1: VGA read request; held until `vga_valid` is seen.
- `vga_addr` in 20: VGA read address; stable while `vga_sel` is high.
- `vga_data` out 48: VGA read data, registered.
- `vga_valid` out 1: one-cycle response pulse to VGA.
- `cpu_sel` in 1: CPU request; held until `cpu_valid` is seen.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 20: CPU address.
- `cpu_wdata` in 48: CPU write data.
- `cpu_rdata` out 48: CPU read data, registered.
- `cpu_valid` out 1: one-cycle response pulse to CPU; also pulses for writes.
- `mem_req` out 1: memory request; held until `mem_ack`.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out 20: memory address.
- `mem_wdata` out 48: memory write data.
- `mem_ack` in 1: memory completion; single cycle.
- `mem_rdata` in 48: memory read data; valid in the `mem_ack` cycle.
- `arb_err` out 1: one-cycle timeout-abort pulse, aligned with the aborted port's valid.

## Operation
- FSM states: IDLE, ISSUE, RESP, GAP.
- IDLE: sample `vga_sel` and `cpu_sel`.
  - Grant VGA if `vga_sel` is high and (`cpu_sel` is low or `burst_cnt` < `VGA_BURST`). Otherwise grant CPU if `cpu_sel` is high.
  - On a grant: latch owner, address, we, and wdata (VGA always we = 0), then go to ISSUE.
- ISSUE: `mem_req` = 1 with the latched fields. On `mem_ack`:
  - capture `mem_rdata` into the owner's data register (reads only);
  - go to RESP.
- RESP: pulse the owner's valid for exactly one cycle, then go to GAP.
- GAP: one dead cycle; all `sel` inputs are ignored so a registered requester can drop `sel`. Then go to IDLE.
- `burst_cnt` (3 bits minimum, sized by `VGA_BURST`):
  - increments on a VGA grant while `cpu_sel` is high, saturating at `VGA_BURST`;
  - clears on any CPU grant;
  - holds otherwise.
- Data registers hold their value until the next response to the same port. Writes do not update `cpu_rdata`.
- Simultaneous requests: VGA wins except when `burst_cnt` == `VGA_BURST`, in which case the CPU wins.
- A `sel` that drops while not granted is simply not served. A `sel` that drops after a grant does not cancel the transfer; the valid still pulses.
- Reset (async, any state):
  - state goes to IDLE;
  - `mem_req`, `mem_we`, `vga_valid`, `cpu_valid`, `arb_err` = 0;
  - `mem_addr`, `mem_wdata`, `vga_data`, `cpu_rdata` = 0;
  - `burst_cnt` = 0.
  
  An in-flight memory access is abandoned; the memory controller must tolerate `mem_req` dropping.

## Timing
- Cycle 0: `sel` high in IDLE. Cycle 1: ISSUE with `mem_req` high. `mem_ack` arrives in cycle k ≥ 1. Cycle k+1: RESP, valid and data together. Cycle k+2: GAP. Cycle k+3: IDLE.
- Minimum request-to-valid latency is 2 cycles. Back-to-back grant spacing is at least 4 cycles.
- `mem_*` outputs are registered and stable throughout ISSUE. `mem_req` falls the cycle after `mem_ack`.
- No two valids ever assert in the same cycle.

## Configuration
- `VRAM_ARB_TIMEOUT_EN` defined:
  - an ISSUE watchdog counts cycles;
  - on reaching `TIMEOUT` without `mem_ack`: drop `mem_req`, force owner data to 48'h0, go to RESP, and pulse `arb_err` together with the valid.
  - The watchdog counter clears on every entry to ISSUE.
- Undefined: ISSUE waits indefinitely; `arb_err` is tied to 0; no watchdog logic is present.

## Structure
- Shared package holds:
  - the state enum (IDLE/ISSUE/RESP/GAP);
  - owner encoding (OWN_VGA/OWN_CPU);
  - `ADDR_W` = 20 and `DATA_W` = 48.
- Sub-module `vram_arb_watchdog` (counter plus compare) is instantiated only under `VRAM_ARB_TIMEOUT_EN`. Everything else stays in one module.

## Test plan
- Single VGA read at address 0x00123 with `mem_ack` 3 cycles after `mem_req` rises, `mem_rdata` 48'h123456789ABC -> `vga_valid` pulses for one cycle, 1 cycle after ack, with `vga_data` = 48'h123456789ABC; `mem_we` = 0 throughout.
- CPU write to 0xFFFFF with data 48'hFFFF_FFFF_FFFF, ack immediate -> `mem_we` = 1 and `mem_addr` = 0xFFFFF during ISSUE; `cpu_valid` pulses once; `cpu_rdata` is unchanged.
- VGA and CPU `sel` held high continuously, `VGA_BURST` = 4 -> grant order V,V,V,V,C,V,V,V,V,C; gap of at least 4 cycles between valids.
- Requester model drops `sel` the cycle after valid -> no duplicate grant during GAP; exactly one valid per request.
- Reset asserted while in ISSUE -> all outputs 0 immediately (asynchronous); after release, a fresh `vga_sel` is served normally with `burst_cnt` starting at 0.
- With `VRAM_ARB_TIMEOUT_EN` and `TIMEOUT` = 8, `mem_ack` never asserted -> `mem_req` drops after 8 cycles; `vga_valid` and `arb_err` pulse together with `vga_data` = 0. Without the macro: still waiting after 1000 cycles.
